cr16_controller: RTL and testbench

Multi-cycle fetch/decode/execute control unit for the CompactRISC16 core, sitting directly upstream of `cr16_datapath`. It does four things:
- fetches 16-bit instructions over a simple request/valid instruction-memory port;
- decodes them into the datapath's register-select, write-enable, immediate and ALU-opcode controls;
- samples the datapath's status flags into an internal PSR;
- maintains the program counter, including conditional branches.

---
 rtl/cr16_pkg.sv | 53 +++++
 rtl/cr16_decoder.sv | 69 ++++++
 rtl/cr16_controller.sv | 122 ++++++++++++
 tb/tb_cr16_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared constants and FSM state type for the CompactRISC16 controller.
// Branch support is built in when CR16_BRANCH_EN is defined; otherwise Bcc decodes as a NOP.
package cr16_pkg;

    // ALU opcodes, shared with cr16_datapath
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // Instruction opcode field; the ALU codes double as R-type ext codes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_BCC   = 4'b1100;
    localparam logic [3:0] CODE_AND = 4'b0001;
    localparam logic [3:0] CODE_OR  = 4'b0010;
    localparam logic [3:0] CODE_XOR = 4'b0011;
    localparam logic [3:0] CODE_ADD = 4'b0101;
    localparam logic [3:0] CODE_SUB = 4'b1001;
    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [3:0] CODE_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_UC = 4'b1110;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

`ifdef CR16_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2
    } state_e;

    // Arithmetic group: sign-extended immediate and PSR update
    function automatic logic is_arith(input logic [3:0] code);
        return (code == CODE_ADD) || (code == CODE_SUB) || (code == CODE_CMP);
    endfunction

endpackage

// File: rtl/cr16_decoder.sv
// Combinational instruction decoder: IR to datapath controls plus write/PSR/branch flags.
// Bcc is recognised only when CR16_BRANCH_EN is defined (see cr16_pkg::BRANCH_EN).
module cr16_decoder
    import cr16_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [3:0]  reg_a_o,
    output logic [3:0]  reg_b_o,
    output logic        imm_sel_o,
    output logic [15:0] imm_o,
    output logic [3:0]  alu_op_o,
    output logic        write_o,
    output logic        psr_upd_o,
    output logic        branch_o
);

    logic [3:0] opcode;
    logic [3:0] code;
    logic [3:0] alu_op;
    logic       is_rtype;
    logic       is_alu;

    always_comb begin
        reg_a_o   = '0;
        reg_b_o   = '0;
        imm_sel_o = 1'b0;
        imm_o     = '0;
        alu_op_o  = '0;
        write_o   = 1'b0;
        psr_upd_o = 1'b0;
        branch_o  = 1'b0;
        alu_op    = '0;
        is_alu    = 1'b1;

        opcode   = ir_i[15:12];
        is_rtype = (opcode == OP_RTYPE);
        // R-type carries its operation in ext; immediate forms reuse the same code as opcode
        code     = is_rtype ? ir_i[7:4] : opcode;

        case (code)
            CODE_ADD: alu_op = ALU_ADD;
            CODE_SUB: alu_op = ALU_SUB;
            CODE_CMP: alu_op = ALU_SUB;
            CODE_AND: alu_op = ALU_AND;
            CODE_OR:  alu_op = ALU_OR;
            CODE_XOR: alu_op = ALU_XOR;
            CODE_MOV: alu_op = ALU_MOV;
            default:  is_alu = 1'b0;
        endcase

        if (is_alu) begin
            reg_a_o   = ir_i[11:8];
            reg_b_o   = ir_i[3:0];
            alu_op_o  = alu_op;
            imm_sel_o = !is_rtype;
            write_o   = (code != CODE_CMP);
            psr_upd_o = is_arith(code);
            if (!is_rtype) begin
                imm_o = is_arith(code) ? {{8{ir_i[7]}}, ir_i[7:0]} : {8'h00, ir_i[7:0]};
            end
        end

        branch_o = BRANCH_EN && (opcode == OP_BCC);
        if (branch_o) begin
            imm_o = {{8{ir_i[7]}}, ir_i[7:0]};
        end
    end

endmodule

// File: rtl/cr16_controller.sv
// CompactRISC16 fetch/decode/execute control unit: FSM, PC, IR and PSR around cr16_decoder.
// Conditional branches are present only when CR16_BRANCH_EN is defined.
module cr16_controller
    import cr16_pkg::*;
#(
    parameter int PC_WIDTH = 16
)(
    input  logic                I_CLK,
    input  logic                I_NRESET,
    input  logic                I_ENABLE,
    output logic [PC_WIDTH-1:0] O_IMEM_ADDR,
    output logic                O_IMEM_REQ,
    input  logic                I_IMEM_VALID,
    input  logic [15:0]         I_IMEM_DATA,
    input  logic [4:0]          I_STATUS_FLAGS,
    output logic [15:0]         O_REG_WRITE_ENABLE,
    output logic [3:0]          O_REG_A_SELECT,
    output logic [3:0]          O_REG_B_SELECT,
    output logic                O_IMMEDIATE_SELECT,
    output logic [15:0]         O_IMMEDIATE,
    output logic [3:0]          O_OPCODE,
    output logic [PC_WIDTH-1:0] O_PC
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [4:0]          psr_q, psr_d;

    logic [3:0]          dec_reg_a, dec_reg_b, dec_alu_op;
    logic [15:0]         dec_imm;
    logic                dec_imm_sel, dec_write, dec_psr_upd, dec_branch;
    logic                in_ctrl, we_active, cond_ok, taken;
    logic [PC_WIDTH-1:0] disp_ext;
    logic                psr_unused;

    cr16_decoder u_decoder (
        .ir_i      (ir_q),
        .reg_a_o   (dec_reg_a),
        .reg_b_o   (dec_reg_b),
        .imm_sel_o (dec_imm_sel),
        .imm_o     (dec_imm),
        .alu_op_o  (dec_alu_op),
        .write_o   (dec_write),
        .psr_upd_o (dec_psr_upd),
        .branch_o  (dec_branch)
    );

    assign disp_ext   = PC_WIDTH'($signed(ir_q[7:0]));
    assign psr_unused = ^{psr_q[FLAG_N], psr_q[FLAG_F], psr_q[FLAG_L]};

    always_comb begin
        cond_ok = 1'b0;
        case (ir_q[11:8])
            COND_EQ: cond_ok = psr_q[FLAG_Z];
            COND_NE: cond_ok = !psr_q[FLAG_Z];
            COND_CS: cond_ok = psr_q[FLAG_C];
            COND_CC: cond_ok = !psr_q[FLAG_C];
            COND_UC: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
        taken = dec_branch && cond_ok;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        psr_d   = psr_q;
        if (I_ENABLE) begin
            case (state_q)
                ST_FETCH: begin
                    if (I_IMEM_VALID) begin
                        ir_d    = I_IMEM_DATA;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: state_d = ST_EXECUTE;
                ST_EXECUTE: begin
                    if (dec_psr_upd) begin
                        psr_d = I_STATUS_FLAGS;
                    end
                    pc_d    = taken ? (pc_q + disp_ext) : (pc_q + PC_WIDTH'(1));
                    state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            psr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            psr_q   <= psr_d;
        end
    end

    // Reset overrides everything combinationally so the outputs are quiet while it is held
    assign in_ctrl   = I_NRESET && ((state_q == ST_DECODE) || (state_q == ST_EXECUTE));
    assign we_active = in_ctrl && I_ENABLE && (state_q == ST_EXECUTE) && dec_write;

    assign O_IMEM_REQ         = I_NRESET && I_ENABLE && (state_q == ST_FETCH);
    assign O_IMEM_ADDR        = I_NRESET ? pc_q : '0;
    assign O_PC               = I_NRESET ? pc_q : '0;
    assign O_REG_A_SELECT     = in_ctrl ? dec_reg_a : '0;
    assign O_REG_B_SELECT     = in_ctrl ? dec_reg_b : '0;
    assign O_IMMEDIATE_SELECT = in_ctrl && dec_imm_sel;
    assign O_IMMEDIATE        = in_ctrl ? dec_imm : '0;
    assign O_OPCODE           = in_ctrl ? dec_alu_op : '0;

    for (genvar gi = 0; gi < 16; gi++) begin : g_we
        assign O_REG_WRITE_ENABLE[gi] = we_active && (dec_reg_a == 4'(gi));
    end

endmodule

// File: tb/tb_cr16_controller.sv
// Self-checking bench for cr16_controller: hand vectors, directed corner sequences and random programs.
`timescale 1ns/1ps
module tb_cr16_controller;

    logic        I_CLK;
    logic        I_NRESET;
    logic        I_ENABLE;
    logic [15:0] O_IMEM_ADDR;
    logic        O_IMEM_REQ;
    logic        I_IMEM_VALID;
    logic [15:0] I_IMEM_DATA;
    logic [4:0]  I_STATUS_FLAGS;
    logic [15:0] O_REG_WRITE_ENABLE;
    logic [3:0]  O_REG_A_SELECT;
    logic [3:0]  O_REG_B_SELECT;
    logic        O_IMMEDIATE_SELECT;
    logic [15:0] O_IMMEDIATE;
    logic [3:0]  O_OPCODE;
    logic [15:0] O_PC;

    cr16_controller #(.PC_WIDTH(16)) dut (
        .I_CLK              (I_CLK),
        .I_NRESET           (I_NRESET),
        .I_ENABLE           (I_ENABLE),
        .O_IMEM_ADDR        (O_IMEM_ADDR),
        .O_IMEM_REQ         (O_IMEM_REQ),
        .I_IMEM_VALID       (I_IMEM_VALID),
        .I_IMEM_DATA        (I_IMEM_DATA),
        .I_STATUS_FLAGS     (I_STATUS_FLAGS),
        .O_REG_WRITE_ENABLE (O_REG_WRITE_ENABLE),
        .O_REG_A_SELECT     (O_REG_A_SELECT),
        .O_REG_B_SELECT     (O_REG_B_SELECT),
        .O_IMMEDIATE_SELECT (O_IMMEDIATE_SELECT),
        .O_IMMEDIATE        (O_IMMEDIATE),
        .O_OPCODE           (O_OPCODE),
        .O_PC               (O_PC)
    );

`ifdef CR16_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ins;
        logic        alu;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        sel;
        logic [15:0] imm;
        logic [3:0]  op;
        logic [15:0] we;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_pc;
    logic [4:0]  exp_psr;
    vec_t        vecs [14];

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written from the instruction-set description
    function automatic vec_t decode_ref(input logic [15:0] ins);
        vec_t       r;
        logic       rtype;
        logic [3:0] code;
        r      = '0;
        r.ins  = ins;
        rtype  = (ins[15:12] == 4'h0);
        code   = rtype ? ins[7:4] : ins[15:12];
        r.alu  = 1'b1;
        case (code)
            4'h5:       r.op = 4'b0000;
            4'h9, 4'hB: r.op = 4'b0100;
            4'h1:       r.op = 4'b0110;
            4'h2:       r.op = 4'b0111;
            4'h3:       r.op = 4'b1000;
            4'hD:       r.op = 4'b1101;
            default:    r.alu = 1'b0;
        endcase
        if (r.alu) begin
            r.a   = ins[11:8];
            r.b   = ins[3:0];
            r.sel = !rtype;
            if (!rtype)
                r.imm = (code inside {4'h5, 4'h9, 4'hB}) ? {{8{ins[7]}}, ins[7:0]} : {8'h00, ins[7:0]};
            r.we  = (code == 4'hB) ? 16'h0000 : (16'h0001 << ins[11:8]);
        end else begin
            r.op = 4'h0;
        end
        return r;
    endfunction

    function automatic bit psr_ref(input logic [15:0] ins);
        logic [3:0] code;
        code = (ins[15:12] == 4'h0) ? ins[7:4] : ins[15:12];
        return code inside {4'h5, 4'h9, 4'hB};
    endfunction

    function automatic bit taken_ref(input logic [15:0] ins);
        bit t;
        case (ins[11:8])
            4'h0:    t = exp_psr[3];
            4'h1:    t = !exp_psr[3];
            4'h2:    t = exp_psr[0];
            4'h3:    t = !exp_psr[0];
            4'hE:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return BR && (ins[15:12] == 4'hC) && t;
    endfunction

    function automatic logic [15:0] rand_ins();
        logic [3:0] codes [7];
        logic [3:0] conds [6];
        logic [3:0] c;
        codes = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
        conds = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hE, 4'h7};
        c     = codes[$urandom_range(0, 6)];
        case ($urandom_range(0, 3))
            0:       return {4'h0, 4'($urandom), c, 4'($urandom)};
            1:       return {c, 12'($urandom)};
            2:       return {4'hC, conds[$urandom_range(0, 5)], 8'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk_idle(input string name);
        chk(name, 64'({O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT,
                       O_IMMEDIATE_SELECT, O_IMMEDIATE, O_OPCODE}), 64'(0));
    endtask

    task automatic chk_ctl(input string ph, input vec_t e, input bit exe);
        chk({ph, "_we"}, 64'(O_REG_WRITE_ENABLE), 64'(exe ? e.we : 16'h0000));
        chk({ph, "_pc"}, 64'(O_PC), 64'(exp_pc));
        if (e.alu) begin
            chk({ph, "_a"}, 64'(O_REG_A_SELECT), 64'(e.a));
            chk({ph, "_sel"}, 64'(O_IMMEDIATE_SELECT), 64'(e.sel));
            chk({ph, "_op"}, 64'(O_OPCODE), 64'(e.op));
            if (e.sel) chk({ph, "_imm"}, 64'(O_IMMEDIATE), 64'(e.imm));
            else       chk({ph, "_b"}, 64'(O_REG_B_SELECT), 64'(e.b));
        end
    endtask

    // One full instruction from the FETCH state, with waits and the flags presented in EXECUTE
    task automatic run_instr(input vec_t e, input logic [4:0] flags, input int waits);
        logic [15:0] pc0;
        pc0 = exp_pc;
        for (int w = 0; w < waits; w++) begin
            I_IMEM_VALID   = 1'b0;
            I_IMEM_DATA    = 16'($urandom);
            I_STATUS_FLAGS = 5'($urandom);
            #1;
            chk("wait_req", 64'(O_IMEM_REQ), 64'(1));
            chk("wait_addr", 64'(O_IMEM_ADDR), 64'(exp_pc));
            chk_idle("wait_idle");
            @(posedge I_CLK); #1;
        end
        I_IMEM_VALID = 1'b1;
        I_IMEM_DATA  = e.ins;
        #1;
        chk("fetch_req", 64'(O_IMEM_REQ), 64'(1));
        chk("fetch_addr", 64'(O_IMEM_ADDR), 64'(exp_pc));
        chk_idle("fetch_idle");
        @(posedge I_CLK); #1;
        I_IMEM_VALID = 1'b0;
        I_IMEM_DATA  = 16'($urandom);
        #1;
        chk("dec_req", 64'(O_IMEM_REQ), 64'(0));
        chk_ctl("dec", e, 1'b0);
        @(posedge I_CLK); #1;
        I_STATUS_FLAGS = flags;
        #1;
        chk_ctl("exe", e, 1'b1);
        @(posedge I_CLK); #1;
        I_STATUS_FLAGS = 5'($urandom);
        if (taken_ref(e.ins)) exp_pc = exp_pc + {{8{e.ins[7]}}, e.ins[7:0]};
        else                  exp_pc = exp_pc + 16'd1;
        if (psr_ref(e.ins)) exp_psr = flags;
        chk("next_pc", 64'(O_PC), 64'(exp_pc));
        $display("instr pc=%h ins=%h flags=%b -> pc=%h", pc0, e.ins, flags, exp_pc);
    endtask

    task automatic do_reset(input int cycles);
        I_NRESET       = 1'b0;
        I_ENABLE       = 1'b1;
        I_IMEM_VALID   = 1'b1;
        I_IMEM_DATA    = 16'($urandom);
        I_STATUS_FLAGS = 5'($urandom);
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("rst_ctl", 64'({O_REG_WRITE_ENABLE, O_REG_A_SELECT, O_REG_B_SELECT,
                                O_IMMEDIATE_SELECT, O_IMMEDIATE, O_OPCODE}), 64'(0));
            chk("rst_pc", 64'({O_IMEM_REQ, O_IMEM_ADDR, O_PC}), 64'(0));
            @(posedge I_CLK); #1;
        end
        I_NRESET     = 1'b1;
        I_IMEM_VALID = 1'b0;
        #1;
        chk("rel_req", 64'(O_IMEM_REQ), 64'(1));
        chk("rel_addr", 64'(O_IMEM_ADDR), 64'(0));
        exp_pc  = 16'h0000;
        exp_psr = 5'h00;
        $display("reset cycles=%0d", cycles);
    endtask

    initial begin
        vecs[0]  = '{16'h53FE, 1'b1, 4'h3, 4'hE, 1'b1, 16'hFFFE, 4'b0000, 16'h0008};
        vecs[1]  = '{16'h01B2, 1'b1, 4'h1, 4'h2, 1'b0, 16'h0000, 4'b0100, 16'h0000};
        vecs[2]  = '{16'h0A15, 1'b1, 4'hA, 4'h5, 1'b0, 16'h0000, 4'b0110, 16'h0400};
        vecs[3]  = '{16'h0F27, 1'b1, 4'hF, 4'h7, 1'b0, 16'h0000, 4'b0111, 16'h8000};
        vecs[4]  = '{16'h0234, 1'b1, 4'h2, 4'h4, 1'b0, 16'h0000, 4'b1000, 16'h0004};
        vecs[5]  = '{16'h0496, 1'b1, 4'h4, 4'h6, 1'b0, 16'h0000, 4'b0100, 16'h0010};
        vecs[6]  = '{16'h07D1, 1'b1, 4'h7, 4'h1, 1'b0, 16'h0000, 4'b1101, 16'h0080};
        vecs[7]  = '{16'h1C80, 1'b1, 4'hC, 4'h0, 1'b1, 16'h0080, 4'b0110, 16'h1000};
        vecs[8]  = '{16'h21FF, 1'b1, 4'h1, 4'hF, 1'b1, 16'h00FF, 4'b0111, 16'h0002};
        vecs[9]  = '{16'h3081, 1'b1, 4'h0, 4'h1, 1'b1, 16'h0081, 4'b1000, 16'h0001};
        vecs[10] = '{16'h9680, 1'b1, 4'h6, 4'h0, 1'b1, 16'hFF80, 4'b0100, 16'h0040};
        vecs[11] = '{16'hB27F, 1'b1, 4'h2, 4'hF, 1'b1, 16'h007F, 4'b0100, 16'h0000};
        vecs[12] = '{16'hD9F0, 1'b1, 4'h9, 4'h0, 1'b1, 16'h00F0, 4'b1101, 16'h0200};
        vecs[13] = '{16'h5580, 1'b1, 4'h5, 4'h0, 1'b1, 16'hFF80, 4'b0000, 16'h0020};

        I_NRESET = 1'b0; I_ENABLE = 1'b1; I_IMEM_VALID = 1'b0;
        I_IMEM_DATA = 16'h0000; I_STATUS_FLAGS = 5'h00;

        // Reset held two cycles, then ADDI with two wait cycles, then the vector table
        do_reset(2);
        run_instr(vecs[0], 5'($urandom), 2);
        chk("addi_pc", 64'(O_PC), 64'(16'h0001));
        for (int i = 1; i < 14; i++) run_instr(vecs[i], 5'($urandom), i % 3);

        // CMP sets Z, then BEQ +4 at PC 5; repeated with Z clear
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(1);
            for (int k = 0; k < 4; k++) run_instr(decode_ref(16'h0000), 5'($urandom), 0);
            run_instr(vecs[1], (pass == 0) ? 5'b01000 : 5'b00000, 1);
            run_instr(decode_ref(16'hC004), 5'($urandom), 0);
            chk("beq_pc", 64'(O_PC), 64'((pass == 0 && BR) ? 16'd9 : 16'd6));
        end

        // Enable dropped in FETCH with valid high: nothing may be latched
        I_ENABLE = 1'b0; I_IMEM_VALID = 1'b1; I_IMEM_DATA = 16'h53FE;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("dis_req", 64'(O_IMEM_REQ), 64'(0));
            chk("dis_addr", 64'(O_IMEM_ADDR), 64'(exp_pc));
            chk_idle("dis_idle");
            @(posedge I_CLK); #1;
        end
        I_ENABLE = 1'b1;
        run_instr(vecs[0], 5'($urandom), 0);

        // Enable dropped in EXECUTE: write strobe suppressed, state and PC held
        I_IMEM_VALID = 1'b1; I_IMEM_DATA = 16'h1C80;
        @(posedge I_CLK); #1;
        I_IMEM_VALID = 1'b0;
        @(posedge I_CLK); #1;
        I_ENABLE = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hold_we", 64'(O_REG_WRITE_ENABLE), 64'(0));
            chk("hold_pc", 64'(O_PC), 64'(exp_pc));
            chk("hold_sel", 64'(O_IMMEDIATE_SELECT), 64'(1));
            @(posedge I_CLK); #1;
        end
        I_ENABLE = 1'b1;
        #1;
        chk("resume_we", 64'(O_REG_WRITE_ENABLE), 64'(16'h1000));
        @(posedge I_CLK); #1;
        exp_pc = exp_pc + 16'd1;
        chk("resume_pc", 64'(O_PC), 64'(exp_pc));
        $display("enable hold in execute -> pc=%h", exp_pc);

        // Reset in EXECUTE abandons the write
        I_IMEM_VALID = 1'b1; I_IMEM_DATA = 16'h53FE;
        @(posedge I_CLK); #1;
        I_IMEM_VALID = 1'b0;
        @(posedge I_CLK); #1;
        I_NRESET = 1'b0;
        #1;
        chk("rst_exe_we", 64'(O_REG_WRITE_ENABLE), 64'(0));
        @(posedge I_CLK); #1;
        I_NRESET = 1'b1;
        #1;
        chk("rst_exe_pc", 64'(O_PC), 64'(0));
        chk("rst_exe_req", 64'(O_IMEM_REQ), 64'(1));
        exp_pc = 16'h0000; exp_psr = 5'h00;
        $display("reset in execute -> pc=0000");

        // BUC -1 at PC 0 wraps; then an increment wraps back; then disp 0 loops
        run_instr(decode_ref(16'hCEFF), 5'($urandom), 0);
        chk("buc_pc", 64'(O_PC), 64'(BR ? 16'hFFFF : 16'h0001));
        run_instr(vecs[2], 5'($urandom), 0);
        run_instr(decode_ref(16'hCE00), 5'($urandom), 1);

        // NOPs must not write or disturb the PSR; BEQ afterwards reveals Z
        do_reset(1);
        run_instr(vecs[1], 5'b01000, 0);
        run_instr(decode_ref(16'hF000), 5'b00000, 0);
        run_instr(decode_ref(16'h0000), 5'b00000, 0);
        run_instr(decode_ref(16'hC002), 5'b00000, 0);
        chk("nop_psr_pc", 64'(O_PC), 64'(BR ? 16'd5 : 16'd4));

        // Random programs
        for (int n = 0; n < 300; n++)
            run_instr(decode_ref(rand_ins()), 5'($urandom), $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
